pipeline_run_controller: RTL and testbench

PIPELINE_RUN_CONTROLLER -- requirements
Module: pipeline_run_controller

---
 rtl/run_ctrl_pkg.sv | 25 ++
 rtl/pipeline_run_controller_if.sv | 33 +++
 rtl/pipeline_run_controller_step_sync.sv | 66 ++++++
 rtl/pipeline_run_controller.sv | 98 +++++++++
 tb/tb_pipeline_run_controller.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/run_ctrl_pkg.sv
// ============================================================================
// Module      : run_ctrl_pkg
// Description : Shared types and default constants for pipeline_run_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package run_ctrl_pkg;

  localparam int c_n_default               = 24;
  localparam int c_flush_cycles_default    = 4;
  localparam int c_debounce_cycles_default = 16;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_FLUSH     = 3'd1,
    ST_RUN       = 3'd2,
    ST_STEP_WAIT = 3'd3,
    ST_STEP      = 3'd4,
    ST_HALT      = 3'd5
  } run_state_e;

endpackage : run_ctrl_pkg

`default_nettype wire

// File: rtl/pipeline_run_controller_if.sv
// ============================================================================
// Module      : pipeline_run_controller_if
// Description : Control/status bundle between the run controller and its host.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_run_controller_if #(
  parameter int N = run_ctrl_pkg::c_n_default
) ();
  logic         pwr;
  logic         dbg;
  logic         stp;
  logic         halt_i;
  logic         cpu_en;
  logic         flush;
  logic         running;
  logic         halted;
  logic [2:0]   state_o;
  logic [N-1:0] cycle_count;

  modport master (
    output pwr, dbg, stp, halt_i,
    input  cpu_en, flush, running, halted, state_o, cycle_count
  );

  modport slave (
    input  pwr, dbg, stp, halt_i,
    output cpu_en, flush, running, halted, state_o, cycle_count
  );
endinterface : pipeline_run_controller_if

`default_nettype wire

// File: rtl/pipeline_run_controller_step_sync.sv
// ============================================================================
// Module      : step_sync
// Description : Step button synchronizer, optional debounce (STEP_DEBOUNCE_EN)
//               and rising-edge detector producing a one-cycle step_pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_sync #(
  parameter int DEBOUNCE_CYCLES = run_ctrl_pkg::c_debounce_cycles_default
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic stp,
  output logic      step_pulse
);

  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= 2'b00;
    else      r_sync <= {r_sync[0], stp};
  end

`ifdef STEP_DEBOUNCE_EN
  localparam int c_cw = $clog2(DEBOUNCE_CYCLES + 1);

  logic [c_cw-1:0] r_cnt;
  logic            r_level;
  logic            r_level_q;

  // The counter only advances while the synchronized input disagrees with the
  // accepted level; any return to agreement restarts the stability window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
    end else begin
      r_level_q <= r_level;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cw'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + c_cw'(1);
      end
    end
  end

  assign step_pulse = r_level & ~r_level_q;
`else
  logic r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_prev <= 1'b0;
    else      r_prev <= r_sync[1];
  end

  assign step_pulse = r_sync[1] & ~r_prev;
`endif

endmodule : step_sync

`default_nettype wire

// File: rtl/pipeline_run_controller.sv
// ============================================================================
// Module      : pipeline_run_controller
// Description : Power/flush/run/single-step/halt sequencer for a CPU pipeline.
//               Optional step debounce enabled by defining STEP_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_run_controller
  import run_ctrl_pkg::*;
#(
  parameter int N               = c_n_default,
  parameter int FLUSH_CYCLES    = c_flush_cycles_default,
  parameter int DEBOUNCE_CYCLES = c_debounce_cycles_default
) (
  input wire logic                 clk,
  input wire logic                 rst,
  pipeline_run_controller_if.slave bus
);

  localparam logic [2:0] S_OFF       = ST_OFF;
  localparam logic [2:0] S_FLUSH     = ST_FLUSH;
  localparam logic [2:0] S_RUN       = ST_RUN;
  localparam logic [2:0] S_STEP_WAIT = ST_STEP_WAIT;
  localparam logic [2:0] S_STEP      = ST_STEP;
  localparam logic [2:0] S_HALT      = ST_HALT;

  localparam int              c_fw         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [c_fw-1:0] c_flush_last = c_fw'(FLUSH_CYCLES - 1);

  if (FLUSH_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("FLUSH_CYCLES and DEBOUNCE_CYCLES must be at least 1");
  end

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [c_fw-1:0] r_flush_cnt;
  logic [N-1:0]    r_count;
  logic            w_cpu_en;
  logic            w_step_pulse;

  step_sync #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_step_sync (
    .clk        (clk),
    .rst        (rst),
    .stp        (bus.stp),
    .step_pulse (w_step_pulse)
  );

  // halt_i is only sampled in states where cpu_en is high (RUN, STEP).
  always_comb begin
    w_next = r_state;
    if (!bus.pwr) begin
      w_next = S_OFF;
    end else begin
      case (r_state)
        S_OFF:       w_next = S_FLUSH;
        S_FLUSH:     if (r_flush_cnt == c_flush_last)
                       w_next = bus.dbg ? S_STEP_WAIT : S_RUN;
        S_RUN:       if (bus.halt_i)     w_next = S_HALT;
                     else if (bus.dbg)   w_next = S_STEP_WAIT;
        S_STEP_WAIT: if (w_step_pulse)   w_next = S_STEP;
                     else if (!bus.dbg)  w_next = S_RUN;
        S_STEP:      w_next = bus.halt_i ? S_HALT : S_STEP_WAIT;
        S_HALT:      w_next = S_HALT;
        default:     w_next = S_OFF;
      endcase
    end
  end

  assign w_cpu_en = (r_state == S_RUN) || (r_state == S_STEP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_OFF;
      r_flush_cnt <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_next;
      r_flush_cnt <= (r_state == S_FLUSH) ? r_flush_cnt + c_fw'(1) : '0;
      if (r_state == S_FLUSH)
        r_count <= '0;
      else if (w_cpu_en && (r_count != {N{1'b1}}))
        r_count <= r_count + N'(1);
    end
  end

  assign bus.cpu_en      = w_cpu_en;
  assign bus.flush       = (r_state == S_FLUSH);
  assign bus.running     = w_cpu_en;
  assign bus.halted      = (r_state == S_HALT);
  assign bus.state_o     = r_state;
  assign bus.cycle_count = r_count;

endmodule : pipeline_run_controller

`default_nettype wire

// File: tb/tb_pipeline_run_controller.sv
// ============================================================================
// Module      : tb_pipeline_run_controller
// Description : Directed self-checking bench for pipeline_run_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_run_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipeline_run_controller_if #(.N(24)) bus  ();
  pipeline_run_controller_if #(.N(4))  bus4 ();

  pipeline_run_controller #(.N(24), .FLUSH_CYCLES(4), .DEBOUNCE_CYCLES(16)) dut (
    .clk (clk), .rst (rst), .bus (bus.slave)
  );

  pipeline_run_controller #(.N(4), .FLUSH_CYCLES(4), .DEBOUNCE_CYCLES(16)) dut4 (
    .clk (clk), .rst (rst), .bus (bus4.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    for (int i = 0; i < budget && bus.state_o != s; i++) tick(1);
    check_eq(tag, 32'(bus.state_o), 32'(s));
  endtask

  task automatic run_count(input int n, output int en);
    en = 0;
    repeat (n) begin
      tick(1);
      if (bus.cpu_en) en++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fl;
    int e1;
    int e2;
    int en;

    bus.pwr = 1'b1;  bus.dbg = 1'b0;  bus.stp = 1'b0;  bus.halt_i = 1'b0;
    bus4.pwr = 1'b1; bus4.dbg = 1'b0; bus4.stp = 1'b0; bus4.halt_i = 1'b0;
    @(negedge clk);
    @(negedge clk);

    check_eq("rst_state",   32'(bus.state_o),     0);
    check_eq("rst_cpu_en",  32'(bus.cpu_en),      0);
    check_eq("rst_flush",   32'(bus.flush),       0);
    check_eq("rst_running", 32'(bus.running),     0);
    check_eq("rst_halted",  32'(bus.halted),      0);
    check_eq("rst_count",   32'(bus.cycle_count), 0);

    // Power-up into free run: four flush cycles, then count ten RUN cycles.
    rst = 1'b1;
    tick(1);
    fl = 0;
    for (int i = 0; i < 20 && bus.flush; i++) begin
      fl++;
      check_eq("flush_no_en", 32'(bus.cpu_en), 0);
      tick(1);
    end
    check_eq("flush_cycles",  fl, 4);
    check_eq("run_state",     32'(bus.state_o), 2);
    check_eq("run_running",   32'(bus.running), 1);
    check_eq("run_count0",    32'(bus.cycle_count), 0);
    tick(10);
    check_eq("run_count10",   32'(bus.cycle_count), 10);
    check_eq("n4_count10",    32'(bus4.cycle_count), 10);

    // Halt from RUN.
    bus.halt_i = 1'b1;
    tick(1);
    bus.halt_i = 1'b0;
    check_eq("halt_state",    32'(bus.state_o), 5);
    check_eq("halt_cpu_en",   32'(bus.cpu_en), 0);
    check_eq("halt_halted",   32'(bus.halted), 1);
    check_eq("halt_count",    32'(bus.cycle_count), 11);
    bus.dbg = 1'b1;
    tick(5);
    bus.dbg = 1'b0;
    check_eq("halt_sticky",   32'(bus.state_o), 5);
    check_eq("halt_count_hold", 32'(bus.cycle_count), 11);
    check_eq("n4_saturate",   32'(bus4.cycle_count), 15);
    tick(20);
    check_eq("n4_no_wrap",    32'(bus4.cycle_count), 15);

    // Power cycle back through FLUSH into single-step mode.
    bus.pwr = 1'b0;
    tick(1);
    check_eq("off_state",     32'(bus.state_o), 0);
    bus.pwr = 1'b1;
    bus.dbg = 1'b1;
    tick(1);
    check_eq("reflush_state", 32'(bus.state_o), 1);
    check_eq("reflush_flag",  32'(bus.flush), 1);
    tick(1);
    check_eq("reflush_count", 32'(bus.cycle_count), 0);
    wait_state(3'd3, 10, "step_wait_entry");

    bus.halt_i = 1'b1;
    tick(3);
    bus.halt_i = 1'b0;
    check_eq("halt_ignored",  32'(bus.state_o), 3);

    en = 0;
    for (int k = 0; k < 3; k++) begin
      bus.stp = 1'b1;
      run_count(40, e1);
      bus.stp = 1'b0;
      check_eq("between_steps", 32'(bus.state_o), 3);
      run_count(40, e2);
      en += e1 + e2;
    end
    check_eq("step_en_cycles", en, 3);
    check_eq("step_count",    32'(bus.cycle_count), 3);
    check_eq("step_wait_end", 32'(bus.state_o), 3);

    bus.dbg = 1'b0;
    tick(1);
    check_eq("wait_to_run",   32'(bus.state_o), 2);
    bus.dbg = 1'b1;
    tick(1);
    check_eq("run_to_wait",   32'(bus.state_o), 3);
    check_eq("run_to_wait_cnt", 32'(bus.cycle_count), 4);

    // A step taken while halt_i is high ends in HALT.
    bus.halt_i = 1'b1;
    bus.stp = 1'b1;
    wait_state(3'd4, 10, "step_entered");
    tick(1);
    check_eq("step_halt",     32'(bus.state_o), 5);
    check_eq("step_halted",   32'(bus.halted), 1);
    bus.halt_i = 1'b0;
    bus.stp = 1'b0;

    // Reset asserted in the middle of a step.
    bus.pwr = 1'b0;
    tick(1);
    bus.pwr = 1'b1;
    wait_state(3'd3, 20, "pre_rst_wait");
    bus.stp = 1'b1;
    wait_state(3'd4, 10, "pre_rst_step");
    rst = 1'b0;
    #1;
    check_eq("rst_step_en",    32'(bus.cpu_en), 0);
    check_eq("rst_step_state", 32'(bus.state_o), 0);
    bus.stp = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Reset asserted in the middle of a flush.
    tick(2);
    check_eq("pre_rst_flush", 32'(bus.flush), 1);
    rst = 1'b0;
    #1;
    check_eq("rst_flush_flag",  32'(bus.flush), 0);
    check_eq("rst_flush_state", 32'(bus.state_o), 0);
    @(negedge clk);
    rst = 1'b1;

`ifdef STEP_DEBOUNCE_EN
    wait_state(3'd3, 20, "db_wait");
    bus.stp = 1'b1;
    run_count(5, e1);
    bus.stp = 1'b0;
    run_count(30, e2);
    check_eq("db_glitch", e1 + e2, 0);
    bus.stp = 1'b1;
    run_count(20, e1);
    bus.stp = 1'b0;
    run_count(30, e2);
    check_eq("db_one_step", e1 + e2, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pipeline_run_controller

`default_nettype wire
